// File: rtl/ysyx_24110015_axi_pkg.sv
// Shared AXI4-Lite response codes, channel FSM states and address decode for the memory responder.
package ysyx_24110015_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // True when addr falls inside [base, base + 4*2^depth_log2).
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input int depth_log2);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> (depth_log2 + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/ysyx_24110015_mem_responder_if.sv
// AXI4-Lite bus between the core (master) and the memory responder (slave).
interface ysyx_24110015_mem_responder_if #(parameter int DATA_W = 32);

    logic [31:0]         araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [31:0]         awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ysyx_24110015_mem_array.sv
// Word array with one async read port and one byte-strobed sync write port.
// A read of the word being written in the same cycle sees the new bytes.
module ysyx_24110015_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = mem[raddr];
        if (we && (waddr == raddr)) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) rdata[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_24110015_mem_responder.sv
// AXI4-Lite slave memory: independent read and write FSMs with programmable response latency
// in front of a word array.
module ysyx_24110015_mem_responder
    import ysyx_24110015_axi_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          RD_LAT     = 1,
    parameter int          WR_LAT     = 1
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_24110015_mem_responder_if.slave bus
);

    localparam logic [3:0] RD_INIT = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [3:0] WR_INIT = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);

    state_t                rd_state, rd_next, wr_state, wr_next;
    logic [3:0]            rd_cnt, rd_cnt_next, wr_cnt, wr_cnt_next;
    logic [31:0]           ar_q, aw_q;
    logic [DATA_W-1:0]     w_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic                  aw_got, w_got;
    logic                  aw_hs, w_hs, rd_enter, wr_enter, rd_ok, wr_ok, we;
    logic [31:0]           rd_addr, wr_addr;
    logic [DATA_W-1:0]     wr_data, arr_rdata;
    logic [DATA_W/8-1:0]   wr_strb;

    assign bus.arready = (rd_state == IDLE);
    assign bus.rvalid  = (rd_state == RESP);
    assign bus.awready = (wr_state == IDLE) && !aw_got;
    assign bus.wready  = (wr_state == IDLE) && !w_got;
    assign bus.bvalid  = (wr_state == RESP);

    // While idle the live bus payload is used so a zero-latency access can hit the array
    // in the same edge as its handshake.
    assign rd_addr = (rd_state == IDLE) ? bus.araddr : ar_q;
    assign wr_addr = aw_got ? aw_q : bus.awaddr;
    assign wr_data = w_got ? w_q : bus.wdata;
    assign wr_strb = w_got ? strb_q : bus.wstrb;
    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign rd_ok   = addr_in_range(rd_addr, BASE, DEPTH_LOG2);
    assign wr_ok   = addr_in_range(wr_addr, BASE, DEPTH_LOG2);

    always_comb begin
        rd_next     = rd_state;
        rd_cnt_next = rd_cnt;
        case (rd_state)
            IDLE: if (bus.arvalid) begin
                if (RD_LAT == 0) rd_next = RESP;
                else begin
                    rd_next     = WAIT;
                    rd_cnt_next = RD_INIT;
                end
            end
            WAIT: if (rd_cnt == 4'd0) rd_next = RESP;
                  else rd_cnt_next = rd_cnt - 4'd1;
            RESP: if (bus.rready) rd_next = IDLE;
            default: rd_next = IDLE;
        endcase
        rd_enter = (rd_next == RESP) && (rd_state != RESP);
    end

    always_comb begin
        wr_next     = wr_state;
        wr_cnt_next = wr_cnt;
        case (wr_state)
            IDLE: if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                if (WR_LAT == 0) wr_next = RESP;
                else begin
                    wr_next     = WAIT;
                    wr_cnt_next = WR_INIT;
                end
            end
            WAIT: if (wr_cnt == 4'd0) wr_next = RESP;
                  else wr_cnt_next = wr_cnt - 4'd1;
            RESP: if (bus.bready) wr_next = IDLE;
            default: wr_next = IDLE;
        endcase
        wr_enter = (wr_next == RESP) && (wr_state != RESP);
        // A reset landing on the commit edge drops the write.
        we       = wr_enter && wr_ok && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= IDLE;
            wr_state  <= IDLE;
            rd_cnt    <= 4'd0;
            wr_cnt    <= 4'd0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            bus.rdata <= '0;
            bus.rresp <= RESP_OKAY;
            bus.bresp <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
            rd_cnt   <= rd_cnt_next;
            wr_cnt   <= wr_cnt_next;
            if (rd_enter) begin
                bus.rdata <= rd_ok ? arr_rdata : '0;
                bus.rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (wr_enter) bus.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
            if ((wr_state == RESP) && bus.bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.arvalid && bus.arready) ar_q <= bus.araddr;
        if (aw_hs) aw_q <= bus.awaddr;
        if (w_hs) begin
            w_q    <= bus.wdata;
            strb_q <= bus.wstrb;
        end
    end

    ysyx_24110015_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .raddr (DEPTH_LOG2'((rd_addr - BASE) >> 2)),
        .rdata (arr_rdata),
        .we    (we),
        .waddr (DEPTH_LOG2'((wr_addr - BASE) >> 2)),
        .wdata (wr_data),
        .wstrb (wr_strb)
    );

endmodule

// File: tb/tb_ysyx_24110015_mem_responder.sv
// Directed bench: dut_a (RD_LAT=2, WR_LAT=1) covers latency, decode, stall and reset; dut_b (0/0) the bypass.
module tb_ysyx_24110015_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24110015_mem_responder_if ifa ();
    ysyx_24110015_mem_responder_if ifb ();

    ysyx_24110015_mem_responder #(.RD_LAT(2), .WR_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    ysyx_24110015_mem_responder #(.RD_LAT(0), .WR_LAT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue AR on ifa from a negedge; returns data, resp, cycles from handshake to rvalid,
    // and whether arready was seen high while waiting.
    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                      output int lat, output logic ar_seen);
        ifa.araddr = a; ifa.arvalid = 1'b1; ifa.rready = 1'b1;
        @(negedge clk);
        ifa.arvalid = 1'b0;
        lat = 1;
        ar_seen = ifa.arready;
        while (!ifa.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
            ar_seen |= ifa.arready;
        end
        d = ifa.rdata; r = ifa.rresp;
        @(negedge clk);
        ifa.rready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r, output int lat);
        ifa.awaddr = a; ifa.awvalid = 1'b1;
        ifa.wdata = d; ifa.wstrb = s; ifa.wvalid = 1'b1; ifa.bready = 1'b1;
        @(negedge clk);
        ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
        lat = 1;
        while (!ifa.bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = ifa.bresp;
        @(negedge clk);
        ifa.bready = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_arready"}, 32'(ifa.arready), 1);
        chk({tag, "_awready"}, 32'(ifa.awready), 1);
        chk({tag, "_wready"},  32'(ifa.wready),  1);
        chk({tag, "_rvalid"},  32'(ifa.rvalid),  0);
        chk({tag, "_bvalid"},  32'(ifa.bvalid),  0);
        chk({tag, "_rdata"},   ifa.rdata,        0);
        chk({tag, "_rresp"},   32'(ifa.rresp),   0);
        chk({tag, "_bresp"},   32'(ifa.bresp),   0);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        ars;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {ifa.araddr, ifa.arvalid, ifa.rready, ifa.awaddr, ifa.awvalid} = '0;
        {ifa.wdata, ifa.wstrb, ifa.wvalid, ifa.bready} = '0;
        {ifb.araddr, ifb.arvalid, ifb.rready, ifb.awaddr, ifb.awvalid} = '0;
        {ifb.wdata, ifb.wstrb, ifb.wvalid, ifb.bready} = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst = 1'b0;
        @(negedge clk);

        // 1: preload then read with RD_LAT=2
        wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, r, lat);
        chk("t1_wr_resp", 32'(r), 0);
        chk("t1_wr_lat", lat, 2);
        rd(32'h8000_0000, d, r, lat, ars);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_rresp", 32'(r), 0);
        chk("t1_rd_lat", lat, 3);
        chk("t1_arready_busy", 32'(ars), 0);

        // 2: W two cycles ahead of AW, partial strobe over a zeroed word
        wr(32'h8000_0010, 32'h0, 4'hF, r, lat);
        ifa.wdata = 32'h1122_3344; ifa.wstrb = 4'b0101; ifa.wvalid = 1'b1; ifa.bready = 1'b1;
        @(negedge clk);
        ifa.wvalid = 1'b0;
        chk("t2_wready_held", 32'(ifa.wready), 0);
        chk("t2_awready_open", 32'(ifa.awready), 1);
        chk("t2_bvalid_t1", 32'(ifa.bvalid), 0);
        @(negedge clk);
        ifa.awaddr = 32'h8000_0010; ifa.awvalid = 1'b1;
        @(negedge clk);
        ifa.awvalid = 1'b0;
        chk("t2_bvalid_t3", 32'(ifa.bvalid), 0);
        @(negedge clk);
        chk("t2_bvalid_t4", 32'(ifa.bvalid), 1);
        chk("t2_bresp", 32'(ifa.bresp), 0);
        @(negedge clk);
        ifa.bready = 1'b0;
        chk("t2_bvalid_done", 32'(ifa.bvalid), 0);
        rd(32'h8000_0010, d, r, lat, ars);
        chk("t2_merged", d, 32'h0022_0044);

        // 3: boundaries and out-of-range on both channels
        wr(32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, r, lat);
        chk("t3_last_wr_resp", 32'(r), 0);
        rd(32'h8000_3FFF, d, r, lat, ars);
        chk("t3_last_rdata", d, 32'h0BAD_F00D);
        chk("t3_last_rresp", 32'(r), 0);
        rd(32'h7FFF_FFFC, d, r, lat, ars);
        chk("t3_oor_rresp", 32'(r), 2);
        chk("t3_oor_rdata", d, 0);
        chk("t3_oor_rd_lat", lat, 3);
        wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, r, lat);
        chk("t3_oor_bresp", 32'(r), 2);
        chk("t3_oor_wr_lat", lat, 2);
        rd(32'h8000_0000, d, r, lat, ars);
        chk("t3_word0_intact", d, 32'hDEAD_BEEF);

        // 4: rready stall, second AR waits for the R handshake
        ifa.araddr = 32'h8000_0010; ifa.arvalid = 1'b1; ifa.rready = 1'b0;
        @(negedge clk);
        ifa.arvalid = 1'b0;
        lat = 1;
        while (!ifa.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_rd_lat", lat, 3);
        ifa.araddr = 32'h8000_0000; ifa.arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rvalid_stall", 32'(ifa.rvalid), 1);
            chk("t4_rdata_stall", ifa.rdata, 32'h0022_0044);
            chk("t4_arready_stall", 32'(ifa.arready), 0);
            @(negedge clk);
        end
        ifa.rready = 1'b1;
        @(negedge clk);
        chk("t4_rvalid_after", 32'(ifa.rvalid), 0);
        chk("t4_arready_after", 32'(ifa.arready), 1);
        @(negedge clk);
        ifa.arvalid = 1'b0;
        chk("t4_ar_taken", 32'(ifa.arready), 0);
        lat = 1;
        while (!ifa.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_rd2_lat", lat, 3);
        chk("t4_rd2_data", ifa.rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        ifa.rready = 1'b0;

        // 5: zero latency, same-cycle read and write to one word (write-first bypass)
        ifb.awaddr = 32'h8000_0020; ifb.awvalid = 1'b1;
        ifb.wdata = 32'h0; ifb.wstrb = 4'hF; ifb.wvalid = 1'b1; ifb.bready = 1'b1;
        @(negedge clk);
        ifb.awvalid = 1'b0; ifb.wvalid = 1'b0;
        chk("t5_clear_bvalid", 32'(ifb.bvalid), 1);
        @(negedge clk);
        ifb.wdata = 32'hA5A5_A5A5; ifb.awvalid = 1'b1; ifb.wvalid = 1'b1;
        ifb.araddr = 32'h8000_0020; ifb.arvalid = 1'b1; ifb.rready = 1'b1;
        @(negedge clk);
        ifb.awvalid = 1'b0; ifb.wvalid = 1'b0; ifb.arvalid = 1'b0;
        chk("t5_rvalid", 32'(ifb.rvalid), 1);
        chk("t5_bvalid", 32'(ifb.bvalid), 1);
        chk("t5_bypass", ifb.rdata, 32'hA5A5_A5A5);
        chk("t5_rresp", 32'(ifb.rresp), 0);
        @(negedge clk);
        ifb.wdata = 32'h1234_5678; ifb.wstrb = 4'b0011; ifb.awvalid = 1'b1; ifb.wvalid = 1'b1;
        ifb.arvalid = 1'b1;
        @(negedge clk);
        ifb.awvalid = 1'b0; ifb.wvalid = 1'b0; ifb.arvalid = 1'b0;
        chk("t5_part_bypass", ifb.rdata, 32'hA5A5_5678);
        chk("t5_part_bvalid", 32'(ifb.bvalid), 1);
        @(negedge clk);
        ifb.rready = 1'b0; ifb.bready = 1'b0;

        // 6: reset while a write sits in WAIT
        ifa.awaddr = 32'h8000_0010; ifa.awvalid = 1'b1;
        ifa.wdata = 32'hFFFF_FFFF; ifa.wstrb = 4'hF; ifa.wvalid = 1'b1; ifa.bready = 1'b1;
        @(negedge clk);
        ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
        chk("t6_in_wait", 32'(ifa.bvalid), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifa.bready = 1'b0;
        chk_reset_outs("t6");
        @(negedge clk);
        chk("t6_no_late_b", 32'(ifa.bvalid), 0);
        rd(32'h8000_0010, d, r, lat, ars);
        chk("t6_old_data", d, 32'h0022_0044);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
